oled_i2c_sequencer: RTL

OLED_I2C_SEQUENCER -- requirements
Module: oled_i2c_sequencer

---
 rtl/oled_i2c_sequencer_pkg.sv | 42 ++++
 rtl/oled_i2c_sequencer_rom.sv | 47 ++++
 rtl/oled_i2c_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/oled_i2c_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// oled_i2c_sequencer_pkg
// Shared definitions for the SSD1306 OLED I2C sequencer: FSM state encoding,
// I2C control-byte constants, sequence lengths, and the column/page window
// command table.
// -----------------------------------------------------------------------------
package oled_i2c_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT_REQ  = 3'd1,
        ST_INIT_WAIT = 3'd2,
        ST_WIN_REQ   = 3'd3,
        ST_WIN_WAIT  = 3'd4,
        ST_DATA_REQ  = 3'd5,
        ST_DATA_WAIT = 3'd6,
        ST_ERROR     = 3'd7
    } seq_state_t;

    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;
    localparam int         INIT_LEN  = 25;
    localparam int         FB_BYTES  = 1024;
    localparam int         WIN_LEN   = 7;

    // Full-screen window: column 0..127, page 0..7. Byte 0 is the control byte.
    function automatic logic [7:0] win_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:    b = CTRL_CMD;
            5'd1:    b = 8'h21;
            5'd2:    b = 8'h00;
            5'd3:    b = 8'h7F;
            5'd4:    b = 8'h22;
            5'd5:    b = 8'h00;
            5'd6:    b = 8'h07;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/oled_i2c_sequencer_rom.sv
// -----------------------------------------------------------------------------
// oled_init_rom
// Combinational SSD1306 power-up command list (25 bytes) for a 128x64 panel:
// display off, clock/mux/offset, charge pump on, horizontal addressing,
// segment/COM remap, contrast, precharge, VCOMH, resume RAM, normal, display on.
// Ports:
//   idx  in  5  command index 0..24 (larger indices read 8'h00)
//   cmd  out 8  command byte
// -----------------------------------------------------------------------------
module oled_init_rom (
    input  logic [4:0] idx,
    output logic [7:0] cmd
);

    always_comb begin
        cmd = 8'h00;
        case (idx)
            5'd0:  cmd = 8'hAE;
            5'd1:  cmd = 8'hD5;
            5'd2:  cmd = 8'h80;
            5'd3:  cmd = 8'hA8;
            5'd4:  cmd = 8'h3F;
            5'd5:  cmd = 8'hD3;
            5'd6:  cmd = 8'h00;
            5'd7:  cmd = 8'h40;
            5'd8:  cmd = 8'h8D;
            5'd9:  cmd = 8'h14;
            5'd10: cmd = 8'h20;   // memory addressing mode
            5'd11: cmd = 8'h00;   // horizontal
            5'd12: cmd = 8'hA1;
            5'd13: cmd = 8'hC8;
            5'd14: cmd = 8'hDA;
            5'd15: cmd = 8'h12;
            5'd16: cmd = 8'h81;
            5'd17: cmd = 8'hCF;
            5'd18: cmd = 8'hD9;
            5'd19: cmd = 8'hF1;
            5'd20: cmd = 8'hDB;
            5'd21: cmd = 8'h40;
            5'd22: cmd = 8'hA4;
            5'd23: cmd = 8'hA6;
            5'd24: cmd = 8'hAF;   // display on
            default: cmd = 8'h00;
        endcase
    end

endmodule

// File: rtl/oled_i2c_sequencer.sv
// -----------------------------------------------------------------------------
// oled_i2c_sequencer
// Drives an I2C write master to initialise an SSD1306 and stream a 1024-byte
// framebuffer to it in CHUNK-sized data transactions, with NACK retry.
//
// state        | meaning
// -------------+------------------------------------------------------------
// IDLE         | waiting for start_init / start_frame
// INIT_REQ     | m_newd high for the 26-byte init transaction
// INIT_WAIT    | init transaction in flight
// WIN_REQ      | m_newd high for the 7-byte window transaction
// WIN_WAIT     | window transaction in flight
// DATA_REQ     | m_newd high for one framebuffer chunk
// DATA_WAIT    | chunk in flight
// ERROR        | retries exhausted; only start_init leaves
//
// Ports:
//   clk, rst (async, active-high)
//   start_init, start_frame         one-cycle requests
//   fb_rd_addr / fb_rd_data         framebuffer read port (1-cycle latency)
//   m_newd, m_op, m_waddr, m_din, m_num_byte_send   I2C master command
//   m_busy, m_done, m_ack_err, m_done_write         I2C master status
//   busy, init_done, frame_done, err, state_o       status
// -----------------------------------------------------------------------------
module oled_i2c_sequencer
    import oled_i2c_sequencer_pkg::*;
#(
    parameter logic [6:0] OLED_ADDR = 7'h3C,
    parameter int         CHUNK     = 16,
    parameter int         MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_init,
    input  logic       start_frame,
    output logic [9:0] fb_rd_addr,
    input  logic [7:0] fb_rd_data,
    output logic       m_newd,
    output logic       m_op,
    output logic [6:0] m_waddr,
    output logic [7:0] m_din,
    output logic [4:0] m_num_byte_send,
    input  logic       m_busy,
    input  logic       m_done,
    input  logic       m_ack_err,
    input  logic       m_done_write,
    output logic       busy,
    output logic       init_done,
    output logic       frame_done,
    output logic       err,
    output logic [2:0] state_o
);

    seq_state_t  state, state_nxt;
    logic [4:0]  idx;
    logic [10:0] chunk_base;
    logic [7:0]  retry;
    logic        ack_lat;
    logic [4:0]  rom_idx;
    logic [7:0]  rom_byte;
    logic        nack, xfer_ok, xfer_nack, retry_exhausted, frame_last;
    logic [10:0] remain, chunk_len;

    assign rom_idx = idx - 5'd1;

    oled_init_rom u_rom (
        .idx (rom_idx),
        .cmd (rom_byte)
    );

    // A NACK reported in the same cycle as m_done still counts.
    assign nack            = ack_lat | m_ack_err;
    assign xfer_ok         = m_done & ~nack;
    assign xfer_nack       = m_done & nack;
    assign retry_exhausted = (retry >= 8'(MAX_RETRY));
    assign remain          = 11'(FB_BYTES) - chunk_base;
    assign chunk_len       = (remain < 11'(CHUNK)) ? remain : 11'(CHUNK);
    assign frame_last      = (chunk_base + 11'(CHUNK)) >= 11'(FB_BYTES);

    assign m_op    = 1'b0;
    assign m_waddr = OLED_ADDR;
    assign state_o = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        m_newd          = 1'b0;
        m_din           = 8'h00;
        m_num_byte_send = 5'd0;
        busy            = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start_init)                    state_nxt = ST_INIT_REQ;
                else if (start_frame && init_done) state_nxt = ST_WIN_REQ;
            end
            ST_INIT_REQ, ST_INIT_WAIT: begin
                m_num_byte_send = 5'(INIT_LEN + 1);
                m_din           = (idx == 5'd0) ? CTRL_CMD : rom_byte;
                if (state == ST_INIT_REQ) begin
                    m_newd = 1'b1;
                    if (m_busy) state_nxt = ST_INIT_WAIT;
                end else if (xfer_ok) begin
                    state_nxt = ST_IDLE;
                end else if (xfer_nack) begin
                    state_nxt = retry_exhausted ? ST_ERROR : ST_INIT_REQ;
                end
            end
            ST_WIN_REQ, ST_WIN_WAIT: begin
                m_num_byte_send = 5'(WIN_LEN);
                m_din           = win_byte(idx);
                if (state == ST_WIN_REQ) begin
                    m_newd = 1'b1;
                    if (m_busy) state_nxt = ST_WIN_WAIT;
                end else if (xfer_ok) begin
                    state_nxt = ST_DATA_REQ;
                end else if (xfer_nack) begin
                    state_nxt = retry_exhausted ? ST_ERROR : ST_WIN_REQ;
                end
            end
            ST_DATA_REQ, ST_DATA_WAIT: begin
                m_num_byte_send = 5'(chunk_len + 11'd1);
                m_din           = (idx == 5'd0) ? CTRL_DATA : fb_rd_data;
                if (state == ST_DATA_REQ) begin
                    m_newd = 1'b1;
                    if (m_busy) state_nxt = ST_DATA_WAIT;
                end else if (xfer_ok) begin
                    state_nxt = frame_last ? ST_IDLE : ST_DATA_REQ;
                end else if (xfer_nack) begin
                    state_nxt = retry_exhausted ? ST_ERROR : ST_DATA_REQ;
                end
            end
            ST_ERROR: begin
                busy = 1'b0;
                if (start_init) state_nxt = ST_INIT_REQ;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= 5'd0;
            chunk_base <= 11'd0;
            retry      <= 8'd0;
            ack_lat    <= 1'b0;
            fb_rd_addr <= 10'd0;
            init_done  <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_INIT_REQ, ST_WIN_REQ, ST_DATA_REQ: begin
                    idx     <= 5'd0;
                    ack_lat <= 1'b0;
                    // Prime the read port with the first payload byte.
                    if (state == ST_DATA_REQ) fb_rd_addr <= chunk_base[9:0];
                end
                ST_INIT_WAIT, ST_WIN_WAIT, ST_DATA_WAIT: begin
                    if (m_ack_err) ack_lat <= 1'b1;
                    if (m_done_write) begin
                        idx <= idx + 5'd1;
                        // Byte 0 is the control byte, so the address only
                        // advances once payload bytes start going out.
                        if (state == ST_DATA_WAIT && idx != 5'd0)
                            fb_rd_addr <= fb_rd_addr + 10'd1;
                    end
                    if (xfer_nack) begin
                        if (retry_exhausted) begin
                            retry <= 8'd0;
                            err   <= 1'b1;
                        end else begin
                            retry <= retry + 8'd1;
                        end
                    end
                    if (xfer_ok) begin
                        retry <= 8'd0;
                        if (state == ST_INIT_WAIT) init_done <= 1'b1;
                        if (state == ST_WIN_WAIT)  chunk_base <= 11'd0;
                        if (state == ST_DATA_WAIT) begin
                            chunk_base <= chunk_base + 11'(CHUNK);
                            if (frame_last) frame_done <= 1'b1;
                        end
                    end
                end
                ST_ERROR: begin
                    if (start_init) begin
                        err       <= 1'b0;
                        init_done <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
